// File: rtl/gol_engine.sv
// Game of Life engine: ROWS x COLS board, row seeding, timed or single-step generations, saturating stats.
// Latency: registered; each generation lands in one edge with a 1-cycle gen_done_o; no backpressure (commands sampled every cycle).
module gol_engine #(
  parameter int ROWS     = 16,
  parameter int COLS     = 16,
  parameter int TICK_DIV = 134217728,
  parameter int CNT_W    = 32
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      cmd_start,
  input  logic                      cmd_pause,
  input  logic                      cmd_step,
  input  logic                      cmd_clear,
  input  logic                      wr_en,
  input  logic [$clog2(ROWS)-1:0]   wr_row,
  input  logic [COLS-1:0]           wr_data,
  input  logic                      wrap_mode,
  output logic [ROWS*COLS-1:0]      board_o,
  output logic [1:0]                state_o,
  output logic [CNT_W-1:0]          gen_cnt_o,
  output logic [CNT_W-1:0]          birth_cnt_o,
  output logic [CNT_W-1:0]          death_cnt_o,
  output logic                      gen_done_o
);

  localparam int N  = ROWS * COLS;
  localparam int RW = $clog2(ROWS);
  localparam int TW = $clog2(TICK_DIV);
  localparam int PW = $clog2(N + 1);
  localparam int SW = ((CNT_W > PW) ? CNT_W : PW) + 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    ST_SET    = 2'b00,
    ST_RUN    = 2'b01,
    ST_PAUSE  = 2'b10,
    ST_STABLE = 2'b11
  } state_t;

  state_t            state, state_nx;
  logic [N-1:0]      board, next_board, written;
  logic [TW-1:0]     tick, tick_nx;
  logic [CNT_W-1:0]  gen_cnt, birth_cnt, death_cnt;
  logic              gen_done;
  logic              do_update, do_write, do_clear, stable;

  // Cells outside the board read as dead unless toroidal wrap is selected.
  function automatic logic cell_at(input logic [N-1:0] b, input logic wrap,
                                   input int rr, input int cc);
    logic [N-1:0] sh;
    logic         in_bounds;
    in_bounds = (rr >= 0) && (rr < ROWS) && (cc >= 0) && (cc < COLS);
    sh = b >> ((((rr + ROWS) % ROWS) * COLS) + ((cc + COLS) % COLS));
    return (in_bounds || wrap) && sh[0];
  endfunction

  function automatic logic [3:0] nbr_count(input logic [N-1:0] b, input logic wrap,
                                           input int r, input int c);
    logic [3:0] n;
    n = '0;
    for (int dr = -1; dr <= 1; dr++)
      for (int dc = -1; dc <= 1; dc++)
        if (dr != 0 || dc != 0)
          n = n + {3'b000, cell_at(b, wrap, r + dr, c + dc)};
    return n;
  endfunction

  function automatic logic [PW-1:0] popcnt(input logic [N-1:0] v);
    logic [PW-1:0] s;
    s = '0;
    for (int i = 0; i < N; i++) s = s + PW'(v[i]);
    return s;
  endfunction

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a, input logic [PW-1:0] b);
    logic [SW-1:0] s;
    s = SW'(a) + SW'(b);
    return (s > SW'({CNT_W{1'b1}})) ? {CNT_W{1'b1}} : s[CNT_W-1:0];
  endfunction

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar c = 0; c < COLS; c++) begin : g_col
      logic [3:0] n;
      assign n = nbr_count(board, wrap_mode, r, c);
      assign next_board[r*COLS+c] = (n == 4'd3) || (board[r*COLS+c] && (n == 4'd2));
    end
    assign written[r*COLS +: COLS] = (wr_row == RW'(r)) ? wr_data : board[r*COLS +: COLS];
  end

  assign stable = (next_board == board);

  // The highest-priority asserted command wins even when it has no effect in the current state.
  always_comb begin
    state_nx  = state;
    tick_nx   = tick;
    do_update = 1'b0;
    do_write  = 1'b0;
    do_clear  = 1'b0;
    if (cmd_clear) begin
      do_clear = 1'b1;
      state_nx = ST_SET;
      tick_nx  = '0;
    end else begin
      case (state)
        ST_SET: begin
          if (cmd_start) begin
            state_nx = ST_RUN;
            tick_nx  = '0;
          end else if (wr_en && !cmd_pause && !cmd_step) begin
            do_write = 1'b1;
          end
        end
        ST_RUN: begin
          if (cmd_pause && !cmd_start) begin
            state_nx = ST_PAUSE;
          end else if (tick == TICK_LAST) begin
            do_update = 1'b1;
            tick_nx   = '0;
            if (stable) state_nx = ST_STABLE;
          end else begin
            tick_nx = tick + TW'(1);
          end
        end
        ST_PAUSE: begin
          if (cmd_start) begin
            state_nx = ST_RUN;
          end else if (cmd_step && !cmd_pause) begin
            do_update = 1'b1;
            if (stable) state_nx = ST_STABLE;
          end else if (wr_en && !cmd_pause && !cmd_step) begin
            do_write = 1'b1;
          end
        end
        default: begin
          if (cmd_start) begin
            state_nx = ST_RUN;
            tick_nx  = '0;
          end else if (cmd_pause) begin
            state_nx = ST_PAUSE;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_SET;
    else          state <= state_nx;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      board     <= '0;
      tick      <= '0;
      gen_cnt   <= '0;
      birth_cnt <= '0;
      death_cnt <= '0;
      gen_done  <= 1'b0;
    end else begin
      tick     <= tick_nx;
      gen_done <= do_update;
      if (do_clear) begin
        board     <= '0;
        gen_cnt   <= '0;
        birth_cnt <= '0;
        death_cnt <= '0;
      end else if (do_update) begin
        board     <= next_board;
        gen_cnt   <= sat_add(gen_cnt, PW'(1));
        birth_cnt <= sat_add(birth_cnt, popcnt(next_board & ~board));
        death_cnt <= sat_add(death_cnt, popcnt(board & ~next_board));
      end else if (do_write) begin
        board <= written;
      end
    end
  end

  assign board_o     = board;
  assign state_o     = state;
  assign gen_cnt_o   = gen_cnt;
  assign birth_cnt_o = birth_cnt;
  assign death_cnt_o = death_cnt;
  assign gen_done_o  = gen_done;

endmodule

// File: tb/tb_gol_engine.sv
// Bench for gol_engine on a 5x5 board: cycle-level reference model plus directed literal checks.
module tb_gol_engine;
  localparam int ROWS     = 5;
  localparam int COLS     = 5;
  localparam int TICK_DIV = 4;
  localparam int CNT_W    = 3;
  localparam int N        = ROWS * COLS;
  localparam int RW       = $clog2(ROWS);
  localparam int MAXC     = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             cmd_start, cmd_pause, cmd_step, cmd_clear;
  logic             wr_en;
  logic [RW-1:0]    wr_row;
  logic [COLS-1:0]  wr_data;
  logic             wrap_mode;
  logic [N-1:0]     board_o;
  logic [1:0]       state_o;
  logic [CNT_W-1:0] gen_cnt_o, birth_cnt_o, death_cnt_o;
  logic             gen_done_o;

  gol_engine #(.ROWS(ROWS), .COLS(COLS), .TICK_DIV(TICK_DIV), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_start(cmd_start), .cmd_pause(cmd_pause), .cmd_step(cmd_step), .cmd_clear(cmd_clear),
    .wr_en(wr_en), .wr_row(wr_row), .wr_data(wr_data), .wrap_mode(wrap_mode),
    .board_o(board_o), .state_o(state_o), .gen_cnt_o(gen_cnt_o),
    .birth_cnt_o(birth_cnt_o), .death_cnt_o(death_cnt_o), .gen_done_o(gen_done_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit cmp_on = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference model: board as a 2-D array, state as spec codes 0..3.
  bit mb [ROWS][COLS];
  bit mn [ROWS][COLS];
  int mst, mtick, mgen, mbirth, mdeath;
  bit mdone;

  function automatic void model_reset();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) mb[r][c] = 0;
    mst = 0; mtick = 0; mgen = 0; mbirth = 0; mdeath = 0; mdone = 0;
  endfunction

  function automatic void life(input bit w);
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) begin
        int n;
        n = 0;
        for (int dr = -1; dr <= 1; dr++)
          for (int dc = -1; dc <= 1; dc++) begin
            int rr, cc;
            rr = r + dr;
            cc = c + dc;
            if (dr == 0 && dc == 0) continue;
            if (w) begin
              rr = (rr + ROWS) % ROWS;
              cc = (cc + COLS) % COLS;
            end else if (rr < 0 || rr >= ROWS || cc < 0 || cc >= COLS) continue;
            n += int'(mb[rr][cc]);
          end
        mn[r][c] = (n == 3) || (mb[r][c] && n == 2);
      end
  endfunction

  function automatic void mwrite();
    if (int'(wr_row) < ROWS)
      for (int c = 0; c < COLS; c++) mb[int'(wr_row)][c] = wr_data[c];
  endfunction

  function automatic logic [N-1:0] pack();
    logic [N-1:0] v;
    v = '0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) v[r*COLS+c] = mb[r][c];
    return v;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) model_reset();
    else begin
      bit upd, same;
      int b, d;
      upd = 0;
      life(wrap_mode);
      same = 1;
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS; c++) if (mn[r][c] != mb[r][c]) same = 0;
      if (cmd_clear) model_reset();
      else begin
        case (mst)
          0: if (cmd_start) begin mst = 1; mtick = 0; end
             else if (!cmd_pause && !cmd_step && wr_en) mwrite();
          1: if (cmd_pause && !cmd_start) mst = 2;
             else if (mtick == TICK_DIV - 1) begin upd = 1; mtick = 0; if (same) mst = 3; end
             else mtick++;
          2: if (cmd_start) mst = 1;
             else if (!cmd_pause && cmd_step) begin upd = 1; if (same) mst = 3; end
             else if (!cmd_pause && !cmd_step && wr_en) mwrite();
          default: if (cmd_start) begin mst = 1; mtick = 0; end
                   else if (cmd_pause) mst = 2;
        endcase
      end
      if (upd) begin
        b = 0; d = 0;
        for (int r = 0; r < ROWS; r++)
          for (int c = 0; c < COLS; c++) begin
            if (mn[r][c] && !mb[r][c]) b++;
            if (mb[r][c] && !mn[r][c]) d++;
          end
        mgen   = (mgen + 1 > MAXC) ? MAXC : mgen + 1;
        mbirth = (mbirth + b > MAXC) ? MAXC : mbirth + b;
        mdeath = (mdeath + d > MAXC) ? MAXC : mdeath + d;
        mb = mn;
      end
      mdone = upd;
    end
  end

  always @(negedge clk) begin
    if (cmp_on) begin
      chk("m_board", board_o, pack());
      chk("m_state", state_o, mst);
      chk("m_gen", gen_cnt_o, mgen);
      chk("m_birth", birth_cnt_o, mbirth);
      chk("m_death", death_cnt_o, mdeath);
      chk("m_done", gen_done_o, mdone);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic cmd(input logic c, input logic s, input logic p, input logic st);
    cmd_clear = c; cmd_start = s; cmd_pause = p; cmd_step = st;
    @(negedge clk);
    cmd_clear = 0; cmd_start = 0; cmd_pause = 0; cmd_step = 0;
  endtask

  task automatic wr(input logic [RW-1:0] r, input logic [COLS-1:0] d);
    wr_en = 1; wr_row = r; wr_data = d;
    @(negedge clk);
    wr_en = 0;
  endtask

  task automatic wait_gen(output int cycles);
    cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
    end while (!gen_done_o && cycles < 50);
    if (!gen_done_o) chk("gen_timeout", {63'b0, gen_done_o}, 64'd1);
  endtask

  task automatic glider_seed();
    wr(3'd0, 5'b00010);
    wr(3'd1, 5'b00100);
    wr(3'd2, 5'b00111);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int n, pulses;
    reset_n = 0; cmd_start = 0; cmd_pause = 0; cmd_step = 0; cmd_clear = 0;
    wr_en = 0; wr_row = '0; wr_data = '0; wrap_mode = 0;
    cyc(2); #1;
    chk("rst_board", board_o, 64'd0);
    chk("rst_state", state_o, 64'd0);
    chk("rst_cnt", {gen_cnt_o, birth_cnt_o, death_cnt_o}, 64'd0);
    chk("rst_done", gen_done_o, 64'd0);
    #1 reset_n = 1;
    cmp_on = 1;
    cyc(1);

    // Blinker, timed generations
    wr(3'd2, 5'b01110);
    chk("wr_visible", board_o, 64'h3800);
    wr(3'd5, 5'b11111);
    chk("wr_oob_ignored", board_o, 64'h3800);
    cmd(0, 1, 0, 0);
    wait_gen(n);
    chk("first_update_latency", n, 4);
    chk("blinker_g1", board_o, 64'h21080);
    wait_gen(n);
    chk("update_period", n, 4);
    chk("blinker_g2", board_o, 64'h3800);
    chk("blinker_gen2", gen_cnt_o, 2);
    chk("blinker_birth2", birth_cnt_o, 4);
    chk("blinker_death2", death_cnt_o, 4);
    chk("blinker_run", state_o, 1);

    // Saturation after 10 generations
    repeat (8) wait_gen(n);
    chk("sat_gen", gen_cnt_o, 7);
    chk("sat_birth", birth_cnt_o, 7);
    chk("sat_death", death_cnt_o, 7);
    chk("sat_board", board_o, 64'h3800);
    chk("sat_run", state_o, 1);

    // Pause beats a simultaneous write; write lands the next cycle
    wr_en = 1; wr_row = 3'd0; wr_data = 5'b00001; cmd_pause = 1;
    @(negedge clk);
    cmd_pause = 0;
    chk("pause_state", state_o, 2);
    chk("pause_no_write", board_o, 64'h3800);
    @(negedge clk);
    wr_en = 0;
    chk("pause_write", board_o, 64'h3801);
    cmd(1, 0, 0, 0);
    chk("clear_board", board_o, 64'd0);
    chk("clear_gen", gen_cnt_o, 0);
    chk("clear_state", state_o, 0);

    // Block is a still life
    wr(3'd1, 5'b00110);
    wr(3'd2, 5'b00110);
    cmd(0, 1, 0, 0);
    wait_gen(n);
    chk("block_latency", n, 4);
    chk("block_board", board_o, 64'h18C0);
    chk("block_state", state_o, 3);
    chk("block_cnt", {gen_cnt_o, birth_cnt_o, death_cnt_o}, {3'd1, 3'd0, 3'd0});
    pulses = 0;
    repeat (12) begin
      @(negedge clk);
      pulses += int'(gen_done_o);
    end
    chk("block_done_once", pulses, 0);

    // Glider on a torus returns home after 20 steps
    cmd(1, 0, 0, 0);
    wrap_mode = 1;
    glider_seed();
    chk("glider_seed", board_o, 64'h1C82);
    cmd(0, 1, 0, 0);
    cmd(0, 0, 1, 0);
    chk("glider_paused", state_o, 2);
    cmd_step = 1;
    cyc(4);
    cmd_step = 0;
    chk("glider_held_step4", board_o, 64'h72080);
    repeat (16) begin
      cmd(0, 0, 0, 1);
      cyc(1);
    end
    chk("glider_wrap20", board_o, 64'h1C82);
    chk("glider_pop", $countones(board_o), 5);
    chk("glider_wrap_state", state_o, 2);
    chk("glider_gen_sat", gen_cnt_o, 7);

    // Same glider with dead border ends as a corner block
    cmd(1, 0, 0, 0);
    wrap_mode = 0;
    glider_seed();
    cmd(0, 1, 0, 0);
    cmd(0, 0, 1, 0);
    repeat (20) begin
      cmd(0, 0, 0, 1);
      cyc(1);
    end
    chk("glider_block", board_o, 64'h18C0000);
    chk("glider_stable", state_o, 3);

    // Asynchronous reset mid-run at tick 2
    cmd(1, 0, 0, 0);
    wr(3'd2, 5'b01110);
    cmd(0, 1, 0, 0);
    wait_gen(n);
    cyc(2);
    #2 reset_n = 0;
    #1;
    chk("arst_board", board_o, 64'd0);
    chk("arst_state", state_o, 0);
    chk("arst_gen", gen_cnt_o, 0);
    #1 reset_n = 1;
    cyc(1);
    wr(3'd2, 5'b01110);
    cmd(0, 1, 0, 0);
    chk("start_after_reset", state_o, 1);
    cmd(1, 1, 0, 0);
    chk("clear_over_start_state", state_o, 0);
    chk("clear_over_start_board", board_o, 64'd0);
    cyc(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
